// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch controller and its BCD counters.
//   sw_state_t : controller mode (RUN / PAUSED / ADJUST)
//   BLANK_CODE : non-numeric digit code that the 7-segment mux shows as a dash
//   MAX_TENS / MAX_ONES : last legal value of each BCD digit of a 00..59 field
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } sw_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] MAX_TENS   = 4'd5;
  localparam logic [3:0] MAX_ONES   = 4'd9;

endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60
// Two-digit BCD counter running 00..59 and wrapping back to 00.
// Ports:
//   CLK   in   system clock
//   RESET in   synchronous, active-high reset (clears to 00)
//   clr   in   synchronous clear to 00, wins over inc
//   inc   in   advance by one
//   ones  out  [3:0] ones digit, 0..9
//   tens  out  [3:0] tens digit, 0..5
//   wrap  out  combinational, high when inc arrives while at 59
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap
);

  logic at_max;

  assign at_max = (ones == MAX_ONES) && (tens == MAX_TENS);
  assign wrap   = inc && at_max;

  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (ones == MAX_ONES) begin
        ones <= '0;
        tens <= (tens == MAX_TENS) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/pause/adjust controller for the stopwatch. Owns the MM:SS BCD time,
// sequences it from internal prescalers and drives the four digit inputs of
// the 7-segment multiplexer, blanking the selected field while adjusting.
// Ports:
//   CLK       in   system clock
//   RESET     in   synchronous, active-high reset
//   BTN_PAUSE in   single-cycle pulse, toggles RUN/PAUSED (ignored in ADJUST)
//   BTN_RST   in   single-cycle pulse, clears time to 00:00
//   ADJ       in   level, 1 = adjust mode
//   SEL       in   level, adjust field: 0 = minutes, 1 = seconds
//   d0..d3    out  [3:0] seconds ones, seconds tens, minutes ones, minutes tens
//   running   out  1 while in RUN
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned FAST_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_PAUSE,
  input  logic       BTN_RST,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int FW = (FAST_DIV  > 1) ? $clog2(FAST_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST  = FW'(FAST_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_next;

  logic [TW-1:0] sec_pre;
  logic [FW-1:0] fast_pre;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blink_phase_next;

  logic          sel_q;
  logic          sel_chg;
  logic          sec_tick;
  logic          fast_wrap;

  logic          sec_inc;
  logic          min_inc;
  logic          sec_wrap;
  logic          min_wrap;
  logic [3:0]    sec_ones;
  logic [3:0]    sec_tens;
  logic [3:0]    min_ones;
  logic [3:0]    min_tens;

  logic          blank_min;
  logic          blank_sec;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= PAUSED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ADJ dominates, leaving ADJUST always lands in PAUSED.
  always_comb begin
    state_next = state;
    if (ADJ) begin
      state_next = ADJUST;
    end else if (state == ADJUST) begin
      state_next = PAUSED;
    end else if (BTN_PAUSE) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  // Second prescaler only advances in RUN, so a pause keeps the sub-second
  // phase and resuming finishes the interrupted second first.
  assign sec_tick = (state == RUN) && (sec_pre == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RESET || BTN_RST) begin
      sec_pre <= '0;
    end else if (state == RUN) begin
      sec_pre <= sec_tick ? '0 : sec_pre + TW'(1);
    end
  end

  // Fast prescaler sits at zero outside ADJUST so entry starts a fresh
  // interval; a field switch restarts it and suppresses that cycle's wrap.
  assign sel_chg   = (SEL != sel_q);
  assign fast_wrap = (state == ADJUST) && !sel_chg && (fast_pre == FAST_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_q    <= 1'b0;
      fast_pre <= '0;
    end else begin
      sel_q <= SEL;
      if ((state != ADJUST) || sel_chg) begin
        fast_pre <= '0;
      end else begin
        fast_pre <= fast_wrap ? '0 : fast_pre + FW'(1);
      end
    end
  end

  // Free-running blink phase, 1 = digits visible.
  assign blink_phase_next = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_phase_next;
    end
  end

  // Adjust increments touch only the selected field; no carry between fields.
  assign sec_inc = sec_tick | (fast_wrap & SEL);
  assign min_inc = ((state == RUN) & sec_wrap) | (fast_wrap & ~SEL);

  bcd_mod60 u_seconds (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (BTN_RST),
    .inc  (sec_inc),
    .ones (sec_ones),
    .tens (sec_tens),
    .wrap (sec_wrap)
  );

  bcd_mod60 u_minutes (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (BTN_RST),
    .inc  (min_inc),
    .ones (min_ones),
    .tens (min_tens),
    .wrap (min_wrap)
  );

  // Carry out of the minutes field is dropped: 59:59 simply rolls to 00:00.
  logic unused_min_wrap;
  assign unused_min_wrap = min_wrap;

  // Registered status: decided from next-cycle state and phase so the flags
  // change on the same edge as the time registers they qualify.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      running   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      running   <= (state_next == RUN);
      blank_min <= (state_next == ADJUST) && !blink_phase_next && !SEL;
      blank_sec <= (state_next == ADJUST) && !blink_phase_next &&  SEL;
    end
  end

  // Output selection between flops only: true BCD or the dash code.
  always_comb begin
    d0 = blank_sec ? BLANK_CODE : sec_ones;
    d1 = blank_sec ? BLANK_CODE : sec_tens;
    d2 = blank_min ? BLANK_CODE : min_ones;
    d3 = blank_min ? BLANK_CODE : min_tens;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with short prescalers. A behavioural
// model tracks minutes/seconds as plain integers, the mode as an integer and
// the blink phase from the edge count since reset; every cycle the DUT
// digits and running flag are compared against it.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int FAST_DIV  = 4;
  localparam int BLINK_DIV = 3;

  localparam int M_RUN    = 0;
  localparam int M_PAUSED = 1;
  localparam int M_ADJUST = 2;

  logic       CLK;
  logic       RESET;
  logic       BTN_PAUSE;
  logic       BTN_RST;
  logic       ADJ;
  logic       SEL;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic       running;

  int   n_compared   = 0;
  int   n_mismatched = 0;

  int   m_mode;
  int   m_mm;
  int   m_ss;
  int   m_pre;
  int   m_fast;
  int   m_edges;
  logic m_sel_prev;

  logic r_adj;
  logic r_sel;
  int   guard;

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .FAST_DIV (FAST_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BTN_PAUSE(BTN_PAUSE),
    .BTN_RST  (BTN_RST),
    .ADJ      (ADJ),
    .SEL      (SEL),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .running  (running)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string tag);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: bound expired, got no event, want event at %0t", tag, $time);
  endtask

  task automatic modelReset();
    m_mode     = M_PAUSED;
    m_mm       = 0;
    m_ss       = 0;
    m_pre      = 0;
    m_fast     = 0;
    m_edges    = 0;
    m_sel_prev = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge model state.
  task automatic modelStep(input logic pause, input logic rst, input logic adj,
                           input logic sel);
    bit tick;
    bit sel_chg;
    bit fwrap;
    int total;
    tick    = (m_mode == M_RUN) && (m_pre == TICK_DIV - 1);
    sel_chg = (sel != m_sel_prev);
    fwrap   = (m_mode == M_ADJUST) && !sel_chg && (m_fast == FAST_DIV - 1);

    if (rst) begin
      m_mm = 0;
      m_ss = 0;
    end else if (tick) begin
      total = (m_mm * 60 + m_ss + 1) % 3600;
      m_mm  = total / 60;
      m_ss  = total % 60;
    end else if (fwrap) begin
      if (sel) m_ss = (m_ss + 1) % 60;
      else     m_mm = (m_mm + 1) % 60;
    end

    if (rst) m_pre = 0;
    else if (m_mode == M_RUN) m_pre = (m_pre + 1) % TICK_DIV;

    if ((m_mode != M_ADJUST) || sel_chg) m_fast = 0;
    else m_fast = (m_fast + 1) % FAST_DIV;

    if (adj) m_mode = M_ADJUST;
    else if (m_mode == M_ADJUST) m_mode = M_PAUSED;
    else if (pause) m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;

    m_sel_prev = sel;
    m_edges++;
  endtask

  function automatic logic [15:0] expDigits(input logic sel);
    logic       blank;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    blank = (m_mode == M_ADJUST) && (((m_edges / BLINK_DIV) % 2) == 1);
    m1 = 4'(m_mm / 10);
    m0 = 4'(m_mm % 10);
    s1 = 4'(m_ss / 10);
    s0 = 4'(m_ss % 10);
    if (blank && !sel) begin
      m1 = 4'hF;
      m0 = 4'hF;
    end
    if (blank && sel) begin
      s1 = 4'hF;
      s0 = 4'hF;
    end
    return {m1, m0, s1, s0};
  endfunction

  task automatic applyStimulus(input logic pause, input logic rst, input logic adj,
                               input logic sel);
    BTN_PAUSE = pause;
    BTN_RST   = rst;
    ADJ       = adj;
    SEL       = sel;
    @(posedge CLK);
    modelStep(pause, rst, adj, sel);
    #1;
    checkOutput("digits", {d3, d2, d1, d0}, expDigits(sel));
    checkOutput("running", {15'd0, running}, {15'd0, (m_mode == M_RUN)});
    BTN_PAUSE = 1'b0;
    BTN_RST   = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    BTN_PAUSE = 1'b0;
    BTN_RST   = 1'b0;
    ADJ       = 1'b0;
    SEL       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    modelReset();
    checkOutput("reset_digits", {d3, d2, d1, d0}, 16'h0000);
    checkOutput("reset_running", {15'd0, running}, 16'h0000);
    RESET = 1'b0;

    // Idle while paused: nothing may count.
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_paused", {d3, d2, d1, d0}, 16'h0000);

    // Run for 25 seconds.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 250; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("run_25s", {d3, d2, d1, d0}, 16'h0025);

    // Pause freezes the value; resuming finishes the held partial second.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("paused_frozen", {d3, d2, d1, d0}, 16'h0025);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_hold", {d3, d2, d1, d0}, 16'h0025);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_early_tick", {d3, d2, d1, d0}, 16'h0026);

    // Preload 59:58 through adjust mode.
    guard = 0;
    while (m_mm != 59 && guard < 400) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    if (m_mm != 59) timeoutFail("preload_minutes");
    guard = 0;
    while (m_ss != 58 && guard < 400) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      guard++;
    end
    if (m_ss != 58) timeoutFail("preload_seconds");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("preload", {d3, d2, d1, d0}, 16'h5958);

    // Roll over through 59:59 to 00:00.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rollover", {d3, d2, d1, d0}, 16'h0000);

    // BTN_RST landing on a seconds tick.
    for (int i = 0; i < 35; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_pre != TICK_DIV - 1 && guard < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (m_pre != TICK_DIV - 1) timeoutFail("wait_tick");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_on_tick", {d3, d2, d1, d0}, 16'h0000);
    checkOutput("rst_keeps_run", {15'd0, running}, 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_pause_digits", {d3, d2, d1, d0}, 16'h0000);
    checkOutput("rst_pause_running", {15'd0, running}, 16'h0000);

    // Adjust minutes with pause pulses that must be ignored.
    for (int i = 0; i < 24; i++) applyStimulus((i == 7) || (i == 15), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("adjust_minutes", {d3, d2, d1, d0}, 16'h0600);
    checkOutput("adjust_exit_paused", {15'd0, running}, 16'h0000);

    // Randomized traffic against the model.
    r_adj = 1'b0;
    r_sel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r_adj = ~r_adj;
      if ($urandom_range(0, 19) == 0) r_sel = ~r_sel;
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, r_adj, r_sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/adjust controller for the stopwatch.
- Owns the MM:SS BCD time registers and sequences them from internal prescalers.
- Drives the four digit inputs (d0..d3) of the 7-segment multiplexer.
- Produces the blink effect in adjust mode by substituting a non-numeric code, which the multiplexer renders as a dash.

Parameters:
- TICK_DIV, 100_000_000: CLK cycles per stopwatch second in RUN.
- FAST_DIV, 50_000_000: CLK cycles per increment of the selected field in ADJUST.
- BLINK_DIV, 25_000_000: CLK cycles per blink-phase toggle.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BTN_PAUSE  in  1  debounced single-cycle pulse; toggles RUN/PAUSED
- BTN_RST  in  1  debounced single-cycle pulse; clears time to 00:00
- ADJ  in  1  level; 1 = adjust mode
- SEL  in  1  level; adjust field select, 0 = minutes, 1 = seconds
- d0  out  4  seconds ones (BCD)
- d1  out  4  seconds tens (BCD)
- d2  out  4  minutes ones (BCD)
- d3  out  4  minutes tens (BCD)
- running  out  1  1 while in RUN

Behaviour:
- Reset: RESET is synchronous, active-high; clock CLK. On reset:
  - state = PAUSED, time = 00:00.
  - All prescalers = 0, blink phase = visible (1).
  - d0..d3 = 0, running = 0.
- States: RUN, PAUSED, ADJUST.
  - PAUSED -> RUN on BTN_PAUSE while ADJ = 0.
  - RUN -> PAUSED on BTN_PAUSE while ADJ = 0.
  - RUN or PAUSED -> ADJUST when ADJ = 1; ADJ has priority over BTN_PAUSE in the same cycle.
  - ADJUST -> PAUSED when ADJ = 0.
  - BTN_PAUSE is ignored in ADJUST.
- Second prescaler:
  - Counts 0..TICK_DIV-1, advancing only in RUN.
  - Holds its value in PAUSED and ADJUST (pause/resume keeps the sub-second phase).
  - Cleared by BTN_RST.
  - Wrap from TICK_DIV-1 to 0 produces a 1-cycle sec_tick.
- RUN counting: sec_tick increments seconds 00..59.
  - Seconds 59 -> 00 carries +1 into minutes.
  - Minutes 59 -> 00 wraps, so 59:59 -> 00:00 with no overflow flag.
- ADJUST counting:
  - Fast prescaler is cleared on entry to ADJUST and counts 0..FAST_DIV-1.
  - Each wrap increments only the SEL field, 59 -> 00, with no carry between fields.
  - A SEL change mid-adjust clears the fast prescaler.
- Blink:
  - Free-running counter toggles blink phase every BLINK_DIV cycles, in all states.
  - In ADJUST with phase = 0, the selected field's two digits output 4'hF; otherwise they output their true BCD value.
- BTN_RST:
  - Clears time to 00:00 and the second prescaler in any state; state is unchanged.
  - Wins over a same-cycle sec_tick or adjust increment.
  - A same-cycle BTN_PAUSE still toggles the state.
- Timing:
  - Outputs are registered; d0..d3 reflect a tick, increment or clear one cycle after the event cycle.
  - running is registered from the state.
- BCD invariant: every internal digit stays in 0..9 and every tens digit in 0..5. The only illegal code ever driven on d0..d3 is 4'hF during blink.

Decomposition:
- Shared package stopwatch_pkg:
  - State enum (RUN, PAUSED, ADJUST).
  - BLANK_CODE = 4'hF.
  - MAX_TENS = 5, MAX_ONES = 9.
- One sub-module, bcd_mod60:
  - Two-digit BCD 00..59 counter with ports clr, inc, ones[3:0], tens[3:0], wrap (combinational, high when inc at 59).
  - Instantiated once for seconds and once for minutes.
  - Minutes inc = (RUN & sec wrap) | (ADJUST & fast wrap & SEL = 0).

Test Plan (TICK_DIV=10, FAST_DIV=4, BLINK_DIV=3):
- Reset held 2 cycles, then 30 idle cycles -> d3..d0 = 0,0,0,0, running = 0 throughout, no counting while PAUSED.
- BTN_PAUSE, then 250 cycles -> running = 1 the cycle after the pulse; at 25 s d3..d0 = 0,0,2,5; BTN_PAUSE then 50 cycles -> value frozen; BTN_PAUSE again -> next increment arrives after the held prescaler remainder, not a full 10 cycles.
- Preload 59:58 via adjust, run 20 cycles -> 59:59, then 00:00; d3..d0 = 0,0,0,0 with no glitch digit > 9.
- ADJ = 1, SEL = 0 from 00:30 for 24 cycles -> minutes = 06, seconds stay 30; minute digits read 4'hF on alternate 3-cycle windows, seconds never blanked.
- ADJ = 1, SEL = 1 at 00:57 for 16 cycles -> seconds 58, 59, 00, 01; minutes stay 00; ADJ = 0 -> PAUSED, running = 0, BTN_PAUSE during ADJ has no effect.
- In RUN at 03:41, BTN_RST coincident with sec_tick -> 00:00 one cycle later, running stays 1; BTN_RST + BTN_PAUSE together -> 00:00 and PAUSED.
